// File: rtl/icache_pkg.sv
// ============================================================================
// Module      : icache_pkg
// Description : Shared geometry, state encoding and filler opcode for the
//               direct-mapped instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pkg;

   localparam int ADDR_BITS   = 10;
   localparam int NUM_BLOCKS  = 8;
   localparam int BLOCK_WORDS = 4;

   localparam int TAG_W  = 3;
   localparam int IDX_W  = 3;
   localparam int OFF_W  = 2;
   localparam int LINE_W = 128;

   // Unused opcode; the cpu decodes it as a no-write no-op.
   localparam logic [31:0] ICACHE_NOP = 32'hFF00_0000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      UPDATE = 2'd2
   } icache_state_t;

endpackage

`default_nettype wire

// File: rtl/icache_word_select.sv
// ============================================================================
// Module      : icache_word_select
// Description : Picks one 32-bit word out of a 128-bit cache line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_word_select
   import icache_pkg::*;
(
   input  logic [LINE_W-1:0] i_line,
   input  logic [OFF_W-1:0]  i_offset,
   output logic [31:0]       o_word
);

   assign o_word = i_line[32*i_offset +: 32];

endmodule

`default_nettype wire

// File: rtl/instruction_cache.sv
// ============================================================================
// Module      : instruction_cache
// Description : Direct-mapped read-only instruction cache, 8 lines x 4 words,
//               combinational hit path and blocking line fill on a miss.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_cache
   import icache_pkg::*;
(
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [31:0]            PC,
   output logic [31:0]            INSTRUCTION,
   output logic                   BUSYWAIT,
   output logic                   MEM_READ,
   output logic [TAG_W+IDX_W-1:0] MEM_ADDRESS,
   input  logic [LINE_W-1:0]      MEM_READDATA,
   input  logic                   MEM_BUSYWAIT
);

   icache_state_t r_state;
   icache_state_t w_next_state;

   logic [NUM_BLOCKS-1:0]  r_valid;
   logic [TAG_W-1:0]       r_tag  [NUM_BLOCKS];
   logic [LINE_W-1:0]      r_data [NUM_BLOCKS];
   logic [LINE_W-1:0]      r_fill;
   logic [TAG_W+IDX_W-1:0] r_miss_addr;

   logic [TAG_W-1:0] w_tag;
   logic [IDX_W-1:0] w_idx;
   logic [OFF_W-1:0] w_off;
   logic             w_in_range;
   logic             w_hit;
   logic [31:0]      w_word;
   logic             w_unused_pc_lsbs;

   assign w_tag            = PC[ADDR_BITS-1 -: TAG_W];
   assign w_idx            = PC[OFF_W+2 +: IDX_W];
   assign w_off            = PC[2 +: OFF_W];
   assign w_unused_pc_lsbs = ^PC[1:0];
   assign w_in_range       = (PC[31:ADDR_BITS] == '0);
   assign w_hit            = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

   icache_word_select u_word_select (
      .i_line   (r_data[w_idx]),
      .i_offset (w_off),
      .o_word   (w_word)
   );

   assign MEM_ADDRESS = r_miss_addr;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_in_range && !w_hit) w_next_state = READ;
         READ:    if (!MEM_BUSYWAIT)        w_next_state = UPDATE;
         UPDATE:                            w_next_state = IDLE;
         default:                           w_next_state = IDLE;
      endcase
   end

   always_comb begin
      INSTRUCTION = ICACHE_NOP;
      BUSYWAIT    = 1'b0;
      MEM_READ    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_in_range) begin
               if (w_hit) INSTRUCTION = w_word;
               else       BUSYWAIT    = 1'b1;
            end
         end
         READ: begin
            MEM_READ = 1'b1;
            BUSYWAIT = 1'b1;
         end
         UPDATE:  BUSYWAIT = 1'b1;
         default: BUSYWAIT = 1'b1;
      endcase
   end

   // Fill bookkeeping; the fill address is latched so a wandering PC cannot redirect it.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_valid     <= '0;
         r_fill      <= '0;
         r_miss_addr <= '0;
      end else begin
         if (r_state == IDLE && w_next_state == READ) begin
            r_miss_addr <= {w_tag, w_idx};
         end
         if (r_state == READ && !MEM_BUSYWAIT) begin
            r_fill <= MEM_READDATA;
         end
         if (r_state == UPDATE) begin
            r_valid[r_miss_addr[IDX_W-1:0]] <= 1'b1;
         end
      end
   end

   // Tag and data storage are never cleared; validity alone gates them.
   always_ff @(posedge CLK) begin
      if (RESET && r_state == UPDATE) begin
         r_tag[r_miss_addr[IDX_W-1:0]]  <= r_miss_addr[IDX_W +: TAG_W];
         r_data[r_miss_addr[IDX_W-1:0]] <= r_fill;
      end
   end

endmodule

`default_nettype wire
